// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Pipeline stages and memory side
  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter: data priority with bounded fetch starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  if (!mem_lat_legal(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT out of range");
  end

  localparam int LW = $clog2(MEM_LAT_MAX + 1);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT);

  arb_state_t        state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [LW-1:0]     lat_cnt, lat_nxt;
  logic              drop, drop_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              we_q, we_nxt;
  logic              if_cand;
  logic              grant_if;
  logic              grant_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_nxt;
      drop       <= drop_nxt;
      starve_cnt <= starve_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      we_q       <= we_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    lat_nxt       = lat_cnt;
    drop_nxt      = drop;
    starve_nxt    = starve_cnt;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    we_nxt        = we_q;
    grant_if      = 1'b0;
    grant_dm      = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_valid  = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_valid  = 1'b0;
    bus.dm_rdata  = '0;
    // A flushed fetch is not a candidate in the cycle the flush is seen
    if_cand       = bus.if_req & ~bus.if_flush;

    // Outputs stay quiet while reset is high so an in-flight access never completes
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (bus.dm_req && (!if_cand || starve_cnt != STARVE_SAT)) begin
            grant_dm = 1'b1;
          end else if (if_cand) begin
            grant_if = 1'b1;
          end

          if (grant_dm) begin
            owner_nxt  = OWN_DM;
            addr_nxt   = bus.dm_addr;
            wdata_nxt  = bus.dm_wdata;
            we_nxt     = bus.dm_we;
            if (!bus.if_req) begin
              starve_nxt = '0;
            end else if (starve_cnt != STARVE_SAT) begin
              starve_nxt = starve_cnt + 1'b1;
            end
          end else if (grant_if) begin
            owner_nxt  = OWN_IF;
            addr_nxt   = bus.if_addr;
            wdata_nxt  = '0;
            we_nxt     = 1'b0;
            starve_nxt = '0;
          end

          if (grant_dm || grant_if) begin
            state_nxt     = BUSY;
            lat_nxt       = LAT_INIT;
            drop_nxt      = 1'b0;
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_nxt;
            bus.mem_addr  = addr_nxt;
            bus.mem_wdata = wdata_nxt;
          end
        end

        BUSY: begin
          bus.mem_addr  = addr_q;
          bus.mem_wdata = wdata_q;
          lat_nxt       = lat_cnt - 1'b1;
          if (owner == OWN_IF && bus.if_flush) begin
            drop_nxt = 1'b1;
          end
          if (lat_cnt == LW'(1)) begin
            state_nxt = IDLE;
            drop_nxt  = 1'b0;
            if (owner == OWN_DM) begin
              bus.dm_valid = 1'b1;
              bus.dm_rdata = we_q ? '0 : bus.mem_rdata;
            end else if (!drop && !bus.if_flush) begin
              bus.if_valid = 1'b1;
              bus.if_rdata = bus.mem_rdata;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.if_stall = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_valid;

endmodule
